// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_pkg
// Purpose  : Shared types and constants for the instruction fetch unit:
//            fetch FSM state encoding, the bubble instruction word and the
//            PC step / alignment constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // sll $0,$0,0 - harmless word presented while no real instruction exists
    localparam logic [31:0] c_nop_word      = 32'h0000_0000;

    // One 32-bit instruction word per fetch
    localparam logic [31:0] c_pc_inc        = 32'd4;

    // Fetch addresses are always word aligned
    localparam logic [31:0] c_pc_align_mask = 32'hFFFF_FFFC;

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Purpose  : One-entry skid buffer holding a fetched word and its address
//            while the downstream stage is stalled.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset (empties the entry)
//            i_load   - capture i_instr/i_pc and mark the entry valid
//            i_drain  - entry consumed; mark it empty
//            i_clear  - flush the entry (takes priority over load/drain)
//            i_instr  - instruction word to capture
//            i_pc     - address of the instruction word
//            o_valid  - entry holds a word
//            o_instr  - held instruction word
//            o_pc     - held instruction address
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            instr_d = i_instr;
            pc_d    = i_pc;
        end else if (i_drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_instr = instr_q;
    assign o_pc    = pc_q;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, fetches words over a
//            req/ready handshake and presents one registered instruction per
//            cycle, with downstream stall, redirect and a one-entry skid.
// Ports    : Clock       - clock, rising edge
//            Reset       - synchronous active-high reset
//            imem_req    - fetch request (address stable until imem_ready)
//            imem_addr   - word-aligned fetch address
//            imem_ready  - response valid this cycle
//            imem_rdata  - fetched instruction word
//            stall       - downstream cannot consume Instruction
//            redirect    - branch/jump taken, restart at redirect_pc
//            redirect_pc - redirect target (bits [1:0] ignored)
//            Instruction - registered instruction to the CPU
//            inst_pc     - address of Instruction
//            inst_valid  - Instruction is real (not a bubble)
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q,      pc_d;
    logic [31:0]  instr_q,   instr_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         valid_q,   valid_d;

    logic         skid_load, skid_drain, skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_instr, skid_pc;

    logic         out_consumed;
    logic         out_free;

    assign out_consumed = valid_q & ~stall;
    assign out_free     = ~valid_q | ~stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (redirect) begin
            // Flush everything; any response arriving this cycle belongs to
            // the old stream and is dropped by simply not capturing it.
            pc_d       = redirect_pc & c_pc_align_mask;
            skid_clear = 1'b1;
            valid_d    = 1'b0;
            instr_d    = NOP_WORD;
            state_d    = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + c_pc_inc;
                        if (out_free) begin
                            instr_d   = imem_rdata;
                            inst_pc_d = pc_q;
                            valid_d   = 1'b1;
                        end else begin
                            // Output is stalled: park the word and stop
                            // requesting until the output drains.
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end else if (out_consumed) begin
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_d    = skid_instr;
                        inst_pc_d  = skid_pc;
                        valid_d    = skid_valid;
                        skid_drain = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC & c_pc_align_mask;
            instr_q   <= NOP_WORD;
            inst_pc_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (Clock),
        .rst     (Reset),
        .i_load  (skid_load),
        .i_drain (skid_drain),
        .i_clear (skid_clear),
        .i_instr (imem_rdata),
        .i_pc    (pc_q),
        .o_valid (skid_valid),
        .o_instr (skid_instr),
        .o_pc    (skid_pc)
    );

    // Request is decoded straight from the state register, so it is glitch
    // free and drops the cycle after reset or on entry to HOLD.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = valid_q;

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Directed self-checking bench for inst_fetch_unit: zero-wait
//            streaming, wait-state memory, stall with skid, redirect, PC
//            wrap-around and reset while holding a skid entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;

    // Second instance exercising PC wrap-around, always zero-wait, no stall
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_inst_pc;
    logic        w_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    // ROM contents: address XOR a fixed pattern, so every word is distinct
    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = rom(imem_addr);
    assign w_rdata    = rom(w_addr);

    inst_fetch_unit u_dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .Instruction (Instruction),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .Clock       (Clock),
        .Reset       (Reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ready  (1'b1),
        .imem_rdata  (w_rdata),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'd0),
        .Instruction (w_instr),
        .inst_pc     (w_inst_pc),
        .inst_valid  (w_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [31:0] saved_addr;
        logic        rdy;
        int          cnt;

        Reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;

        // ---------------- reset state + zero-wait streaming ----------------
        tick(); tick();
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_instr", Instruction, 32'h0000_0000);
        check_eq("rst_pc",    inst_pc, 32'd0);
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, 32'd0);
        check_eq("rst_waddr", w_addr, 32'hFFFF_FFF8);
        Reset = 1'b0;
        tick();  // IDLE -> FETCH; ready in IDLE must be ignored
        check_eq("idle_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("fetch_req",  {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", imem_addr, 32'd0);
        check_eq("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        tick();
        check_eq("zw_valid0", {31'd0, inst_valid}, 32'd1);
        check_eq("zw_instrA", Instruction, 32'hA5A5_0000);
        check_eq("zw_pc0",    inst_pc, 32'h0);
        check_eq("wrap_pc0",  w_inst_pc, 32'hFFFF_FFF8);
        check_eq("wrap_ins0", w_instr, 32'h5A5A_FFF8);
        tick();
        check_eq("zw_valid1", {31'd0, inst_valid}, 32'd1);
        check_eq("zw_instrB", Instruction, 32'hA5A5_0004);
        check_eq("zw_pc4",    inst_pc, 32'h4);
        check_eq("wrap_pc1",  w_inst_pc, 32'hFFFF_FFFC);
        tick();
        check_eq("zw_instrC", Instruction, 32'hA5A5_0008);
        check_eq("zw_pc8",    inst_pc, 32'h8);
        check_eq("wrap_pc2",  w_inst_pc, 32'h0000_0000);
        check_eq("wrap_ins2", w_instr, 32'hA5A5_0000);
        tick();
        check_eq("zw_instrD", Instruction, 32'hA5A5_000C);
        check_eq("zw_pcC",    inst_pc, 32'hC);
        check_eq("zw_valid3", {31'd0, inst_valid}, 32'd1);
        check_eq("wrap_pc3",  w_inst_pc, 32'h0000_0004);

        // ---------------- stall with skid capture ----------------
        Reset = 1'b1; tick(); Reset = 1'b0;
        tick();          // IDLE -> FETCH
        tick();          // A@0
        tick();          // B@4
        check_eq("st_pre_pc", inst_pc, 32'h4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("st_hold_instr", Instruction, 32'hA5A5_0004);
            check_eq("st_hold_pc",    inst_pc, 32'h4);
            check_eq("st_hold_req",   {31'd0, imem_req}, 32'd0);
            check_eq("st_hold_valid", {31'd0, inst_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check_eq("st_relC_instr", Instruction, 32'hA5A5_0008);
        check_eq("st_relC_pc",    inst_pc, 32'h8);
        tick();
        check_eq("st_relD_instr", Instruction, 32'hA5A5_000C);
        check_eq("st_relD_pc",    inst_pc, 32'hC);
        tick();
        check_eq("st_relE_pc",    inst_pc, 32'h10);

        // ---------------- redirect coinciding with a response ----------------
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_eq("rd_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rd_nop",   Instruction, 32'h0000_0000);
        check_eq("rd_addr",  imem_addr, 32'h0000_0100);
        check_eq("rd_req",   {31'd0, imem_req}, 32'd1);
        tick();
        check_eq("rd_instr", Instruction, 32'hA5A5_0100);
        check_eq("rd_pc",    inst_pc, 32'h100);
        check_eq("rd_valid2", {31'd0, inst_valid}, 32'd1);

        // ---------------- two wait states per fetch ----------------
        Reset = 1'b1; imem_ready = 1'b0; tick(); Reset = 1'b0;
        tick();          // IDLE -> FETCH
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            rdy        = (cnt == 2);
            imem_ready = rdy;
            saved_addr = imem_addr;
            tick();
            check_eq("ws_valid", {31'd0, inst_valid}, {31'd0, rdy});
            check_eq("ws_addr",  imem_addr, rdy ? saved_addr + 32'd4 : saved_addr);
            if (rdy) check_eq("ws_instr", Instruction, rom(saved_addr));
            cnt = rdy ? 0 : cnt + 1;
        end

        // ---------------- reset while HOLD has a full skid ----------------
        imem_ready = 1'b1;
        tick();          // a valid word reaches the output
        stall = 1'b1;
        tick();          // next word parked in the skid
        check_eq("rh_req_hold", {31'd0, imem_req}, 32'd0);
        Reset = 1'b1;
        tick();
        check_eq("rh_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rh_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rh_addr",  imem_addr, 32'd0);
        Reset = 1'b0; stall = 1'b0;
        tick();
        check_eq("rh_noskid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("rh_first_instr", Instruction, 32'hA5A5_0000);
        check_eq("rh_first_pc",    inst_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of MIPS_CPU.
- Owns the PC, issues word fetches to the instruction memory (INST_ROM or a variable-latency memory) over a req/ready handshake, and presents one registered instruction per cycle to the CPU's Instruction input.
- Supports downstream stall, branch/jump redirect, and a one-entry skid buffer so no fetched word is lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word driven on Instruction when inst_valid=0 (sll $0,$0,0).

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held with imem_addr stable until imem_ready.
- imem_addr  out  32  word-aligned fetch address (bits[1:0]=0).
- imem_ready  in  1  response valid this cycle; imem_rdata valid when high.
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  downstream cannot consume Instruction this cycle.
- redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
- redirect_pc  in  32  target address; bits[1:0] ignored (forced 0).
- Instruction  out  32  instruction to CPU (registered).
- inst_pc  out  32  address of Instruction.
- inst_valid  out  1  Instruction is real (not bubble).

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, inst_valid=0, Instruction=NOP_WORD, inst_pc=0, skid empty, imem_req=0.
- Consume rule: the output is consumed in any cycle with inst_valid=1 and stall=0.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: one cycle after reset, then FETCH. imem_req=0.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ready with output free (inst_valid=0, or consumed this cycle): Instruction<=rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4. Stay in FETCH.
  - On imem_ready with output stalled (inst_valid=1 and stall=1): skid<={rdata,pc}, pc<=pc+4, go to HOLD.
  - No imem_ready and output consumed: inst_valid<=0, Instruction<=NOP_WORD.
- HOLD: imem_req=0. When stall=0, skid moves to the output (inst_valid=1), skid is emptied, go to FETCH.
- Latency: a zero-wait memory (ready tied 1) gives a sustained 1 instr/cycle. First valid Instruction appears 2 cycles after Reset deasserts.
- Redirect has priority over everything except Reset. On redirect:
  - pc<=redirect_pc&~3; skid cleared; inst_valid<=0; Instruction<=NOP_WORD; next state FETCH.
  - Any imem_ready in the same cycle is discarded.
  - imem_addr may change while imem_req=1 only on redirect; memory must serve the latest address.
- Redirect while stall=1 still flushes the output; downstream owns squash ordering.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 -> 0x0000_0000, no flag.
- Reset mid-fetch drops imem_req the next cycle; an in-flight response is ignored.
- imem_ready outside FETCH is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE/FETCH/HOLD), NOP_WORD constant, PC_INC=4.
- One natural sub-module: fetch_skid_buf, holding {valid, instr, pc}, with load/drain/clear controls.

Test Plan:
- Zero-wait memory, ROM[0..3]=A,B,C,D; Reset 2 cycles then release -> inst_pc 0,4,8,C on consecutive cycles with A..D; inst_valid continuous from the 2nd cycle after release.
- Memory with 2 wait cycles per fetch -> inst_valid pattern 1,0,0 repeating; imem_addr stable while imem_req is high.
- Zero-wait; stall=1 for 3 cycles while Instruction=B@4 -> Instruction holds B; C@8 captured in skid; imem_req=0. Release -> C then D@C with no loss or duplication.
- redirect=1 with redirect_pc=0x0000_0103 in the same cycle as imem_ready -> response dropped; next imem_addr=0x100; one bubble (NOP_WORD, inst_valid=0); then ROM[0x100].
- RESET_PC=0xFFFF_FFF8, zero-wait -> fetches at FFF8, FFFC, 0000, 0004.
- Reset asserted during HOLD with skid full -> next cycle inst_valid=0, imem_req=0, pc=RESET_PC; skid content never emitted.
